// File: rtl/router_pkg.sv
// Shared router helpers: index and credit-counter widths derived from block parameters.
package router_pkg;

    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int credit_w(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping at N (any N, not just powers of two).
module rr_arbiter
    import router_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = lane_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          grant_valid,
    output logic [IW-1:0] grant
);

    int idx;

    // Scan from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = ptr;
        idx         = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant       = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/vc_output_scheduler.sv
// Drain-side VC scheduler: round-robin pop of credited, non-empty lanes into a one-cycle output register.
module vc_output_scheduler
    import router_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CREDITS    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LANES-1:0]          lane_empty,
    input  logic [DATA_WIDTH-1:0]     lane_dout,
    output logic                      pop,
    output logic [$clog2(LANES)-1:0]  pop_lane,
    input  logic [LANES-1:0]          credit_return,
    output logic                      out_valid,
    output logic [$clog2(LANES)-1:0]  out_lane,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      credit_err
);

    localparam int IW = lane_w(LANES);
    localparam int CW = credit_w(CREDITS);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    typedef logic [IW-1:0] lane_t;

    logic [CW-1:0]    credit [LANES];
    lane_t            rr_ptr;
    lane_t            grant;
    logic             grant_valid;
    logic [LANES-1:0] eligible;
    logic [LANES-1:0] granted;
    logic [LANES-1:0] err_hit;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < LANES; i++)
            eligible[i] = !lane_empty[i] && (credit[i] != '0);
    end

    rr_arbiter #(.N(LANES)) u_arb (
        .req         (eligible),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // No pops leave the block while reset is held, whatever the lane state.
    assign pop      = grant_valid && reset;
    assign pop_lane = grant;

    always_comb begin
        granted = '0;
        err_hit = '0;
        for (int i = 0; i < LANES; i++) begin
            granted[i] = pop && (grant == IW'(i));
            err_hit[i] = credit_return[i] && !granted[i] && (credit[i] == FULL);
        end
    end

    // Grant and return in the same cycle cancel; an overflowing return saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) credit[i] <= FULL;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (granted[i] && !credit_return[i])
                    credit[i] <= credit[i] - CW'(1);
                else if (!granted[i] && credit_return[i] && (credit[i] != FULL))
                    credit[i] <= credit[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            out_valid  <= 1'b0;
            out_lane   <= '0;
            out_data   <= '0;
            credit_err <= 1'b0;
        end else begin
            out_valid <= pop;
            if (pop) begin
                rr_ptr   <= (grant == IW'(LANES - 1)) ? '0 : grant + 1'b1;
                out_lane <= grant;
                out_data <= lane_dout;
            end
            if (|err_hit) credit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Directed bench for vc_output_scheduler: a 2-lane and a 3-lane instance sharing clock and reset.
module tb_vc_output_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [1:0]  lane_empty = 2'b11;
    logic [1:0]  credit_return = 2'b00;
    logic [31:0] lane_dout;
    logic        pop;
    logic [0:0]  pop_lane;
    logic        out_valid;
    logic [0:0]  out_lane;
    logic [31:0] out_data;
    logic        credit_err;

    logic [2:0]  lane_empty3 = 3'b111;
    logic [2:0]  credit_return3 = 3'b000;
    logic [31:0] lane_dout3;
    logic        pop3;
    logic [1:0]  pop_lane3;
    logic        out_valid3;
    logic [1:0]  out_lane3;
    logic [31:0] out_data3;
    logic        credit_err3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Lane buffer model: head flit encodes the addressed lane.
    assign lane_dout  = 32'hC0DE_0000 + {31'd0, pop_lane};
    assign lane_dout3 = 32'hB000_0000 + {30'd0, pop_lane3};

    vc_output_scheduler #(.LANES(2), .DATA_WIDTH(32), .CREDITS(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .lane_empty    (lane_empty),
        .lane_dout     (lane_dout),
        .pop           (pop),
        .pop_lane      (pop_lane),
        .credit_return (credit_return),
        .out_valid     (out_valid),
        .out_lane      (out_lane),
        .out_data      (out_data),
        .credit_err    (credit_err)
    );

    vc_output_scheduler #(.LANES(3), .DATA_WIDTH(32), .CREDITS(5)) dut3 (
        .clk           (clk),
        .reset         (reset),
        .lane_empty    (lane_empty3),
        .lane_dout     (lane_dout3),
        .pop           (pop3),
        .pop_lane      (pop_lane3),
        .credit_return (credit_return3),
        .out_valid     (out_valid3),
        .out_lane      (out_lane3),
        .out_data      (out_data3),
        .credit_err    (credit_err3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        lane_empty     = 2'b11;
        lane_empty3    = 3'b111;
        credit_return  = 2'b00;
        credit_return3 = 3'b000;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    int seq3 [8] = '{2, 0, 2, 0, 2, 0, 1, 2};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_credit_err", credit_err, 0);
        chk("rst_pop", pop, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Both lanes busy: alternate 0,1 until both run dry after 10 grants
        lane_empty = 2'b00;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("alt_pop", pop, 1);
            chk("alt_pop_lane", pop_lane, k % 2);
            if (k > 0) begin
                chk("alt_out_valid", out_valid, 1);
                chk("alt_out_lane", out_lane, (k - 1) % 2);
                chk("alt_out_data", out_data, 32'hC0DE_0000 + (k - 1) % 2);
            end
            step();
        end
        chk("alt_dry_pop", pop, 0);
        chk("alt_last_valid", out_valid, 1);
        chk("alt_last_lane", out_lane, 1);
        chk("alt_last_data", out_data, 32'hC0DE_0001);
        step();
        chk("alt_idle_valid", out_valid, 0);
        chk("alt_hold_lane", out_lane, 1);

        // Only lane 1: five pops, stall, single return gives a pop next cycle
        do_reset();
        lane_empty = 2'b01;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("l1_pop", pop, 1);
            chk("l1_pop_lane", pop_lane, 1);
            if (k > 0) chk("l1_out_valid", out_valid, 1);
            step();
        end
        chk("l1_stall_pop", pop, 0);
        chk("l1_stall_lane_ptr", pop_lane, 0);
        chk("l1_fifth_valid", out_valid, 1);
        step();
        chk("l1_stall_pop2", pop, 0);
        chk("l1_stall_valid", out_valid, 0);
        credit_return = 2'b10;
        #1;
        chk("l1_no_bypass", pop, 0);
        step();
        credit_return = 2'b00;
        #1;
        chk("l1_ret_pop", pop, 1);
        chk("l1_ret_lane", pop_lane, 1);
        step();
        chk("l1_after_pop", pop, 0);
        chk("l1_after_valid", out_valid, 1);
        chk("l1_after_data", out_data, 32'hC0DE_0001);

        // Lane 0 at credit 1: grant plus return leaves it at 1
        do_reset();
        lane_empty = 2'b10;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("c1_pop", pop, 1);
            chk("c1_pop_lane", pop_lane, 0);
            step();
        end
        chk("c1_last_pop", pop, 1);
        credit_return = 2'b01;
        #1;
        chk("c1_both_pop", pop, 1);
        step();
        credit_return = 2'b00;
        #1;
        chk("c1_still_eligible", pop, 1);
        step();
        chk("c1_dry", pop, 0);
        chk("c1_no_err", credit_err, 0);

        // Return at full credit: saturate and set sticky error
        do_reset();
        credit_return = 2'b01;
        #1;
        step();
        credit_return = 2'b00;
        #1;
        chk("err_set", credit_err, 1);
        lane_empty = 2'b10;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("err_full_pop", pop, 1);
            step();
        end
        chk("err_saturated", pop, 0);
        chk("err_sticky", credit_err, 1);

        // Asynchronous reset mid-stream
        do_reset();
        lane_empty = 2'b00;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("ms_pop_lane", pop_lane, k % 2);
            step();
        end
        chk("ms_valid_before", out_valid, 1);
        reset = 1'b0;
        credit_return = 2'b11;
        #1;
        chk("ms_async_valid", out_valid, 0);
        chk("ms_async_lane", out_lane, 0);
        chk("ms_async_pop", pop, 0);
        credit_return = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("ms_re_pop", pop, 1);
            chk("ms_re_lane", pop_lane, k % 2);
            step();
        end
        chk("ms_re_dry", pop, 0);

        // Three lanes, lane 1 drained: it rejoins in round-robin order after a return
        do_reset();
        lane_empty3 = 3'b101;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("l3_drain_pop", pop3, 1);
            chk("l3_drain_lane", pop_lane3, 1);
            step();
        end
        chk("l3_drained", pop3, 0);
        lane_empty3 = 3'b000;
        for (int k = 0; k < 8; k++) begin
            credit_return3 = (k == 4) ? 3'b010 : 3'b000;
            #1;
            chk("l3_pop", pop3, 1);
            chk("l3_order", pop_lane3, seq3[k]);
            step();
            chk("l3_out_lane", out_lane3, seq3[k]);
            chk("l3_out_data", out_data3, 32'hB000_0000 + seq3[k]);
        end
        chk("l3_no_err", credit_err3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_output_scheduler.md
# vc_output_scheduler

Drain-side scheduler for a router input's multilane (virtual-channel) buffer. Each cycle it picks one non-empty lane that holds downstream credit, issues the pop to the buffer, and forwards the flit to the link with its lane tag. It tracks per-lane downstream credits and replenishes them from credit-return pulses. It sits between the per-port lane buffer and the output link or crossbar stage.

## Interface
- LANES, default 2: number of virtual channels; must be ≥ 2.
- DATA_WIDTH, default 32: flit width.
- CREDITS, default 5: downstream buffer depth per lane, which is also the initial credit count.

Ports:
- clk  input  1: sole clock; all state is on the rising edge.
- reset  input  1: asynchronous, active-low (0 = reset asserted).
- lane_empty  input  LANES: per-lane empty flags from the lane buffer.
- lane_dout  input  DATA_WIDTH: head flit of the lane currently addressed by pop_lane; combinational from the buffer.
- pop  output  1: pop strobe to the lane buffer.
- pop_lane  output  $clog2(LANES): lane being popped.
- credit_return  input  LANES: one-cycle pulse per freed downstream slot, per lane.
- out_valid  output  1: flit valid on the link (registered).
- out_lane  output  $clog2(LANES): lane tag of the flit (registered).
- out_data  output  DATA_WIDTH: flit payload (registered).
- credit_err  output  1: sticky flag; a credit was returned while that lane was already at CREDITS.

## Operation
- credit[i] is a counter of width $clog2(CREDITS+1). Reset value is CREDITS.
- eligible[i] = !lane_empty[i] && credit[i] != 0.
- Arbitration is round-robin. The first eligible lane at or after rr_ptr wins, searching upward and wrapping from LANES-1 to 0. The search is correct for non-power-of-two LANES.
- pop = |eligible and pop_lane = grant. Both are combinational from registered state and lane_empty.
- When no lane is eligible, pop = 0 and pop_lane holds rr_ptr. It must not glitch onto a lane with credit 0.
- On a grant of lane g, rr_ptr becomes (g+1) mod LANES. With no grant, rr_ptr holds. Reset value is 0.
- Credit update per lane:
  - Grant only: decrement.
  - Return only: increment.
  - Grant and return in the same cycle: unchanged.
- A return when credit = CREDITS and no grant on that lane: the counter stays at CREDITS and credit_err sets. credit_err clears only on reset.
- Output register: on a grant, out_valid, out_lane and out_data load 1, g and lane_dout. With no grant, out_valid loads 0; out_lane and out_data hold their values.
- Reset values: out_valid 0, out_lane 0, out_data 0, credit_err 0, rr_ptr 0, all credits at CREDITS.
- Reset asserted mid-operation:
  - Outputs clear immediately (asynchronous).
  - Any in-flight credit returns are lost; all credits restore to CREDITS.
  - pop is forced to 0 while reset is low.

## Timing
- pop issued in cycle t gives out_valid = 1 with that flit in cycle t+1. Latency is one cycle.
- Sustained throughput is one flit per cycle, with no bubble between back-to-back grants, including grants to the same lane.
- A credit returned in cycle t is usable for a grant in cycle t+1. There is no same-cycle bypass.
- Credit reaching 0 in cycle t makes that lane ineligible in cycle t+1.
- A lane_empty rise in cycle t is honoured in the same cycle because it is a combinational input.

## Structure
- Shared package router_pkg holds:
  - the lane index type (logic [$clog2(LANES)-1:0]);
  - the credit-width helper function $clog2(CREDITS+1).
- Sub-module rr_arbiter:
  - parameter N;
  - inputs: request vector, pointer;
  - outputs: grant_valid, grant index.
- Credit counters and the output register stay in vc_output_scheduler.

## Test plan
- Reset release, lanes 0 and 1 both non-empty, no returns:
  - grants alternate 0,1,0,1…;
  - after 10 grants both credits are 0 and pop = 0;
  - out_lane on the link matches the pop order one cycle later.
- Only lane 1 non-empty, CREDITS=5:
  - 5 consecutive pops with out_valid high for 5 cycles;
  - then stall;
  - a single credit_return[1] in cycle t gives pop in cycle t+1.
- Lane 0 at credit 1, grant and credit_return[0] in the same cycle: credit stays 1 and lane 0 remains eligible next cycle.
- credit_return[0] pulsed at full credit (5): credit stays 5, credit_err goes to 1 and stays 1 until reset.
- Reset asserted mid-stream with out_valid = 1:
  - out_valid drops asynchronously before the next edge;
  - after release all credits are 5 and rr_ptr is 0, so lane 0 is granted first.
- LANES=3, all lanes non-empty, lane 1 at credit 0: grants go 0,2,0,2…; after a return on lane 1, the next grant order includes 1 in round-robin position.
